// File: rtl/pipeline_scoreboard_if.sv
// Decode-side bundle for the pipeline scoreboard: issue/operand inputs and hazard outputs.
// The master modport belongs to decode, the slave modport to the scoreboard.
interface pipeline_scoreboard_if #(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 3,
   parameter int SLOT_W = $clog2(DEPTH),
   parameter int CNT_W  = 16
);
   logic              i_issue_valid;
   logic              i_issue_we;
   logic              i_issue_load;
   logic [ADDR_W-1:0] i_issue_dest;
   logic [ADDR_W-1:0] i_src_a;
   logic [ADDR_W-1:0] i_src_b;
   logic              i_src_a_used;
   logic              i_src_b_used;
   logic              i_flush;
   logic              o_stall;
   logic              o_fwd_a_valid;
   logic              o_fwd_b_valid;
   logic [SLOT_W-1:0] o_fwd_a_slot;
   logic [SLOT_W-1:0] o_fwd_b_slot;
   logic [SLOT_W:0]   o_inflight;
   logic [CNT_W-1:0]  o_stall_count;

   modport master (
      output i_issue_valid, i_issue_we, i_issue_load, i_issue_dest,
             i_src_a, i_src_b, i_src_a_used, i_src_b_used, i_flush,
      input  o_stall, o_fwd_a_valid, o_fwd_b_valid, o_fwd_a_slot, o_fwd_b_slot,
             o_inflight, o_stall_count
   );

   modport slave (
      input  i_issue_valid, i_issue_we, i_issue_load, i_issue_dest,
             i_src_a, i_src_b, i_src_a_used, i_src_b_used, i_flush,
      output o_stall, o_fwd_a_valid, o_fwd_b_valid, o_fwd_a_slot, o_fwd_b_slot,
             o_inflight, o_stall_count
   );
endinterface

// File: rtl/pipeline_scoreboard.sv
// In-flight register-write tracker: shifts issued writes through DEPTH slots and resolves
// each source operand to a forwarding slot or a load-use stall, with a saturating stall counter.
module pipeline_scoreboard #(
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 3,
   parameter int LOAD_LAT = 1,
   parameter int SLOT_W   = $clog2(DEPTH),
   parameter int CNT_W    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clk_enable,
   pipeline_scoreboard_if.slave  bus
);

   typedef struct packed {
      logic              valid;
      logic              load;
      logic [ADDR_W-1:0] dest;
   } slot_t;

   typedef struct packed {
      logic              hit;
      logic              load;
      logic [SLOT_W-1:0] idx;
   } match_t;

   slot_t [DEPTH-1:0] r_slots;
   logic  [CNT_W-1:0] r_stall_count;

   match_t            w_a_match;
   match_t            w_b_match;
   logic              w_a_active;
   logic              w_b_active;
   logic              w_a_ready;
   logic              w_b_ready;
   logic              w_a_unready;
   logic              w_b_unready;
   logic              w_stall;
   logic              w_accept;
   slot_t             w_new_slot;
   logic [SLOT_W:0]   w_inflight;

   // Scan oldest to youngest so the last hit written is the youngest producer.
   function automatic match_t find_match(input slot_t [DEPTH-1:0] slots,
                                         input logic [ADDR_W-1:0] src);
      match_t m;
      m = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (slots[k].valid && slots[k].dest == src) begin
            m.hit  = 1'b1;
            m.load = slots[k].load;
            m.idx  = SLOT_W'(k);
         end
      end
      return m;
   endfunction

   // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
   always_comb begin
      w_a_match   = find_match(r_slots, bus.i_src_a);
      w_b_match   = find_match(r_slots, bus.i_src_b);
      w_a_active  = bus.i_issue_valid && bus.i_src_a_used && (bus.i_src_a != '0);
      w_b_active  = bus.i_issue_valid && bus.i_src_b_used && (bus.i_src_b != '0);
      w_a_ready   = !w_a_match.load || (int'(w_a_match.idx) >= LOAD_LAT);
      w_b_ready   = !w_b_match.load || (int'(w_b_match.idx) >= LOAD_LAT);
      w_a_unready = w_a_active && w_a_match.hit && !w_a_ready;
      w_b_unready = w_b_active && w_b_match.hit && !w_b_ready;
      w_stall     = (w_a_unready || w_b_unready) && !bus.i_flush;
      w_accept    = bus.i_issue_valid && !bus.i_flush && !w_stall;

      w_new_slot       = '0;
      w_new_slot.valid = w_accept && bus.i_issue_we && (bus.i_issue_dest != '0);
      w_new_slot.load  = bus.i_issue_load;
      w_new_slot.dest  = bus.i_issue_dest;

      w_inflight = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_inflight = w_inflight + (SLOT_W + 1)'(r_slots[k].valid);
      end
   end

   assign bus.o_stall       = w_stall;
   assign bus.o_fwd_a_valid = w_a_active && w_a_match.hit && w_a_ready;
   assign bus.o_fwd_b_valid = w_b_active && w_b_match.hit && w_b_ready;
   assign bus.o_fwd_a_slot  = bus.o_fwd_a_valid ? w_a_match.idx : '0;
   assign bus.o_fwd_b_slot  = bus.o_fwd_b_valid ? w_b_match.idx : '0;
   assign bus.o_inflight    = w_inflight;
   assign bus.o_stall_count = r_stall_count;

   // NOTE: the slots are a handful of flops rather than a RAM, so clearing them on reset is cheap
   // and required; state uses non-blocking assignments so the shift reads pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slots       <= '0;
         r_stall_count <= '0;
      end else if (clk_enable) begin
         r_slots <= {r_slots[DEPTH-2:0], w_new_slot};
         if (w_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Directed bench for pipeline_scoreboard (DEPTH=3, LOAD_LAT=1, CNT_W=4 so saturation is reachable).
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
module tb_pipeline_scoreboard;
   localparam int ADDR_W   = 5;
   localparam int DEPTH    = 3;
   localparam int LOAD_LAT = 1;
   localparam int SLOT_W   = $clog2(DEPTH);
   localparam int CNT_W    = 4;

   logic clk;
   logic rst_n;
   logic clk_enable;
   int   n_checks;
   int   n_errors;

   pipeline_scoreboard_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SLOT_W(SLOT_W), .CNT_W(CNT_W)) bus ();

   pipeline_scoreboard #(
      .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SLOT_W(SLOT_W), .CNT_W(CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clk_enable (clk_enable),
      .bus        (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic valid, input logic we, input logic load,
                        input logic [ADDR_W-1:0] dest,
                        input logic [ADDR_W-1:0] sa, input logic sa_used,
                        input logic [ADDR_W-1:0] sb, input logic sb_used,
                        input logic flush);
      bus.i_issue_valid = valid;
      bus.i_issue_we    = we;
      bus.i_issue_load  = load;
      bus.i_issue_dest  = dest;
      bus.i_src_a       = sa;
      bus.i_src_a_used  = sa_used;
      bus.i_src_b       = sb;
      bus.i_src_b_used  = sb_used;
      bus.i_flush       = flush;
      #1;
   endtask

   task automatic set_idle();
      drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      set_idle();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      clk_enable = 1'b1;
      set_idle();
      #2;
      n_checks++; if (bus.o_stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b exp 0", bus.o_stall); end
      n_checks++; if (bus.o_inflight !== 3'd0) begin n_errors++; $display("FAIL reset_inflight: got %0d exp 0", bus.o_inflight); end
      n_checks++; if (bus.o_stall_count !== 4'd0) begin n_errors++; $display("FAIL reset_count: got %0d exp 0", bus.o_stall_count); end
      rst_n = 1'b1;
      tick();
      tick();
      n_checks++; if (bus.o_fwd_a_valid !== 1'b0 || bus.o_fwd_b_valid !== 1'b0) begin n_errors++; $display("FAIL idle_fwd_valid: got %b%b exp 00", bus.o_fwd_a_valid, bus.o_fwd_b_valid); end
      n_checks++; if (bus.o_fwd_a_slot !== 2'd0 || bus.o_fwd_b_slot !== 2'd0) begin n_errors++; $display("FAIL idle_fwd_slot: got %0d/%0d exp 0/0", bus.o_fwd_a_slot, bus.o_fwd_b_slot); end
      n_checks++; if (bus.o_inflight !== 3'd0 || bus.o_stall !== 1'b0) begin n_errors++; $display("FAIL idle_state: inflight %0d stall %b exp 0 0", bus.o_inflight, bus.o_stall); end
   endtask

   task automatic test_forward();
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 5'd5, '0, 1'b0, '0, 1'b0, 1'b0);
      tick();
      // non-writing consumer of r5
      drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0);
      n_checks++; if (bus.o_fwd_a_valid !== 1'b1 || bus.o_fwd_a_slot !== 2'd0) begin n_errors++; $display("FAIL fwd_a_slot0: got v=%b s=%0d exp v=1 s=0", bus.o_fwd_a_valid, bus.o_fwd_a_slot); end
      n_checks++; if (bus.o_stall !== 1'b0 || bus.o_fwd_b_valid !== 1'b0) begin n_errors++; $display("FAIL fwd_a_side: stall %b fwd_b %b exp 0 0", bus.o_stall, bus.o_fwd_b_valid); end
      n_checks++; if (bus.o_inflight !== 3'd1) begin n_errors++; $display("FAIL fwd_inflight: got %0d exp 1", bus.o_inflight); end
      tick();
      drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      n_checks++; if (bus.o_fwd_b_valid !== 1'b1 || bus.o_fwd_b_slot !== 2'd1) begin n_errors++; $display("FAIL fwd_b_slot1: got v=%b s=%0d exp v=1 s=1", bus.o_fwd_b_valid, bus.o_fwd_b_slot); end
      tick();
      set_idle();
   endtask

   task automatic test_load_use();
      do_reset();
      drive(1'b1, 1'b1, 1'b1, 5'd7, '0, 1'b0, '0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 1'b0, 5'd8, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
      n_checks++; if (bus.o_stall !== 1'b1 || bus.o_fwd_b_valid !== 1'b0) begin n_errors++; $display("FAIL load_use_c1: stall %b fwd_b %b exp 1 0", bus.o_stall, bus.o_fwd_b_valid); end
      tick();
      n_checks++; if (bus.o_stall !== 1'b0 || bus.o_fwd_b_valid !== 1'b1 || bus.o_fwd_b_slot !== 2'd1) begin n_errors++; $display("FAIL load_use_c2: stall %b v=%b s=%0d exp 0 1 1", bus.o_stall, bus.o_fwd_b_valid, bus.o_fwd_b_slot); end
      n_checks++; if (bus.o_stall_count !== 4'd1) begin n_errors++; $display("FAIL load_use_count: got %0d exp 1", bus.o_stall_count); end
      tick();
      set_idle();
      n_checks++; if (bus.o_inflight !== 3'd2 || bus.o_stall_count !== 4'd1) begin n_errors++; $display("FAIL load_use_after: inflight %0d count %0d exp 2 1", bus.o_inflight, bus.o_stall_count); end
   endtask

   task automatic test_youngest();
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 5'd3, '0, 1'b0, '0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 1'b0, 5'd9, '0, 1'b0, '0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 1'b0, 5'd3, '0, 1'b0, '0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0);
      n_checks++; if (bus.o_fwd_a_valid !== 1'b1 || bus.o_fwd_a_slot !== 2'd0) begin n_errors++; $display("FAIL youngest_a: got v=%b s=%0d exp v=1 s=0", bus.o_fwd_a_valid, bus.o_fwd_a_slot); end
      n_checks++; if (bus.o_fwd_b_valid !== 1'b1 || bus.o_fwd_b_slot !== 2'd1) begin n_errors++; $display("FAIL youngest_b: got v=%b s=%0d exp v=1 s=1", bus.o_fwd_b_valid, bus.o_fwd_b_slot); end
      n_checks++; if (bus.o_inflight !== 3'd3 || bus.o_stall !== 1'b0) begin n_errors++; $display("FAIL youngest_state: inflight %0d stall %b exp 3 0", bus.o_inflight, bus.o_stall); end
      tick();
      set_idle();
   endtask

   task automatic test_flush_reset();
      do_reset();
      drive(1'b1, 1'b1, 1'b1, 5'd7, '0, 1'b0, '0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 1'b0, 5'd10, 5'd7, 1'b1, '0, 1'b0, 1'b1);
      n_checks++; if (bus.o_stall !== 1'b0 || bus.o_fwd_a_valid !== 1'b0) begin n_errors++; $display("FAIL flush_stall: stall %b fwd_a %b exp 0 0", bus.o_stall, bus.o_fwd_a_valid); end
      tick();
      drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 1'b1, 5'd10, 1'b1, 1'b0);
      n_checks++; if (bus.o_inflight !== 3'd1) begin n_errors++; $display("FAIL flush_bubble: inflight %0d exp 1", bus.o_inflight); end
      n_checks++; if (bus.o_fwd_a_slot !== 2'd1 || bus.o_fwd_b_valid !== 1'b0) begin n_errors++; $display("FAIL flush_lookup: a_slot %0d b_valid %b exp 1 0", bus.o_fwd_a_slot, bus.o_fwd_b_valid); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.o_inflight !== 3'd0 || bus.o_fwd_a_valid !== 1'b0) begin n_errors++; $display("FAIL mid_reset: inflight %0d fwd_a %b exp 0 0", bus.o_inflight, bus.o_fwd_a_valid); end
      rst_n = 1'b1;
      set_idle();
      tick();
   endtask

   task automatic test_zero_reg();
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 5'd0, '0, 1'b0, '0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
      n_checks++; if (bus.o_inflight !== 3'd0) begin n_errors++; $display("FAIL zero_dest: inflight %0d exp 0", bus.o_inflight); end
      n_checks++; if (bus.o_fwd_a_valid !== 1'b0 || bus.o_fwd_b_valid !== 1'b0 || bus.o_stall !== 1'b0) begin n_errors++; $display("FAIL zero_src: a %b b %b stall %b exp 0 0 0", bus.o_fwd_a_valid, bus.o_fwd_b_valid, bus.o_stall); end
      tick();
      set_idle();
   endtask

   task automatic test_clk_enable();
      do_reset();
      drive(1'b1, 1'b1, 1'b1, 5'd7, '0, 1'b0, '0, 1'b0, 1'b0);
      tick();
      clk_enable = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 5'd4, 5'd7, 1'b1, '0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (bus.o_stall !== 1'b1 || bus.o_inflight !== 3'd1) begin n_errors++; $display("FAIL hold_%0d: stall %b inflight %0d exp 1 1", i, bus.o_stall, bus.o_inflight); end
         tick();
      end
      n_checks++; if (bus.o_stall_count !== 4'd0) begin n_errors++; $display("FAIL hold_count: got %0d exp 0", bus.o_stall_count); end
      clk_enable = 1'b1;
      tick();
      n_checks++; if (bus.o_stall_count !== 4'd1 || bus.o_stall !== 1'b0 || bus.o_fwd_a_slot !== 2'd1) begin n_errors++; $display("FAIL resume: count %0d stall %b a_slot %0d exp 1 0 1", bus.o_stall_count, bus.o_stall, bus.o_fwd_a_slot); end
      set_idle();
   endtask

   task automatic test_saturate();
      do_reset();
      // A self-dependent load stalls on every second edge.
      drive(1'b1, 1'b1, 1'b1, 5'd7, 5'd7, 1'b1, '0, 1'b0, 1'b0);
      for (int i = 0; i < 28; i++) tick();
      n_checks++; if (bus.o_stall_count !== 4'd14) begin n_errors++; $display("FAIL sat_pre: got %0d exp 14", bus.o_stall_count); end
      for (int i = 0; i < 2; i++) tick();
      n_checks++; if (bus.o_stall_count !== 4'd15) begin n_errors++; $display("FAIL sat_reach: got %0d exp 15", bus.o_stall_count); end
      for (int i = 0; i < 8; i++) tick();
      n_checks++; if (bus.o_stall_count !== 4'd15) begin n_errors++; $display("FAIL sat_hold: got %0d exp 15", bus.o_stall_count); end
      set_idle();
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      rst_n      = 1'b0;
      clk_enable = 1'b1;
      test_reset();
      test_forward();
      test_load_use();
      test_youngest();
      test_flush_reset();
      test_zero_reg();
      test_clk_enable();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
